// File: rtl/fluxo_dados_sequencia.sv
// -----------------------------------------------------------------------------
// fluxo_dados_sequencia
//
// Game datapath for the chess-square sequence trainer. Each round draws a
// SEQ_LEN-entry target sequence from a free-running LFSR. The player then
// submits moves, and each one is checked against the current target. The block
// keeps a countdown timer (with a miss penalty), a saturating score with a
// streak bonus, and the round status.
//
// Ports
//   clock, reset                 : clock, synchronous active-high reset
//   novo_desafio                 : start a new round (ignored while GERANDO)
//   zera_pontos                  : clear score and streak (wins over updates)
//   jogada_linha/jogada_coluna   : player's move
//   jogou                        : level; its rising edge submits the move
//   linha/coluna_esperada        : current target (0 outside ESPERA/AVALIA)
//   indice                       : targets hit in this round
//   pontos                       : score
//   tempo                        : remaining timer ticks
//   acertou, errou               : one-cycle result pulses
//   completo, fim_tempo, ocupado : round status levels
//   db_linha, db_coluna          : last registered move
//   db_estado                    : encoded FSM state
//
// Move handshake: there is no back-pressure. A move is accepted only on a
// cycle in ESPERA where jogou is high and its previous sample was low. Edges
// seen in any other state are dropped, not queued, so the player has to
// release and press again.
// -----------------------------------------------------------------------------
module fluxo_dados_sequencia #(
  parameter int W       = 4,
  parameter int SEQ_LEN = 4,
  parameter int T_MAX   = 30000,
  parameter int T_PEN   = 1000,
  parameter int PTS_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             novo_desafio,
  input  logic             zera_pontos,
  input  logic [W-1:0]     jogada_linha,
  input  logic [W-1:0]     jogada_coluna,
  input  logic             jogou,
  output logic [W-1:0]     linha_esperada,
  output logic [W-1:0]     coluna_esperada,
  output logic [3:0]       indice,
  output logic [PTS_W-1:0] pontos,
  output logic [14:0]      tempo,
  output logic             acertou,
  output logic             errou,
  output logic             completo,
  output logic             fim_tempo,
  output logic             ocupado,
  output logic [W-1:0]     db_linha,
  output logic [W-1:0]     db_coluna,
  output logic [2:0]       db_estado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    GERANDO   = 3'd1,
    ESPERA    = 3'd2,
    AVALIA    = 3'd3,
    CONCLUIDO = 3'd4,
    FIM_TEMPO = 3'd5
  } estado_t;

  // The score sum carries three spare bits, which is enough for
  // 1 + streak + SEQ_LEN on top of a full-scale score.
  localparam int              SW       = PTS_W + 3;
  localparam logic [15:0]     SEED     = 16'hACE1;
  localparam logic [14:0]     T_MAX_V  = 15'(T_MAX);
  localparam logic [14:0]     T_PEN_V  = 15'(T_PEN);
  localparam logic [3:0]      LAST_IDX = 4'(SEQ_LEN - 1);
  localparam logic [SW-1:0]   SEQ_V    = SW'(SEQ_LEN);
  localparam logic [SW-1:0]   PTS_MAX  = {3'b000, {PTS_W{1'b1}}};

  estado_t          estado_q, estado_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             jogou_prev_q;
  logic [W-1:0]     alvo_lin_q [16];
  logic [W-1:0]     alvo_col_q [16];
  logic             alvo_we;
  logic [3:0]       gen_q, gen_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       streak_q, streak_d;
  logic [14:0]      tempo_q, tempo_d;
  logic [PTS_W-1:0] pontos_q, pontos_d;
  logic [W-1:0]     db_lin_q, db_lin_d;
  logic [W-1:0]     db_col_q, db_col_d;
  logic             acertou_q, acertou_d;
  logic             errou_q, errou_d;

  logic             subida;
  logic             hit;
  logic             ultimo;
  logic [14:0]      tempo_dec;
  logic [SW-1:0]    soma_add;
  logic [SW-1:0]    soma;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign subida    = jogou & ~jogou_prev_q;
  assign hit       = (db_lin_q == alvo_lin_q[idx_q]) && (db_col_q == alvo_col_q[idx_q]);
  assign ultimo    = (idx_q == LAST_IDX);
  assign tempo_dec = (tempo_q == 15'd0) ? 15'd0 : tempo_q - 15'd1;
  // The streak is already saturated at 3, so adding it directly gives the
  // min(streak,3) bonus.
  assign soma_add  = SW'(1) + SW'(streak_q) + (ultimo ? SEQ_V : '0);
  assign soma      = {3'b000, pontos_q} + soma_add;

  always_comb begin
    estado_d  = estado_q;
    gen_d     = gen_q;
    idx_d     = idx_q;
    streak_d  = streak_q;
    tempo_d   = tempo_q;
    pontos_d  = pontos_q;
    db_lin_d  = db_lin_q;
    db_col_d  = db_col_q;
    acertou_d = 1'b0;
    errou_d   = 1'b0;
    alvo_we   = 1'b0;

    if (novo_desafio && (estado_q != GERANDO)) begin
      // A new round also aborts an evaluation in flight. The score is kept.
      estado_d = GERANDO;
      gen_d    = '0;
      idx_d    = '0;
      streak_d = '0;
      tempo_d  = T_MAX_V;
    end else begin
      unique case (estado_q)
        GERANDO: begin
          alvo_we = 1'b1;
          if (gen_q == LAST_IDX) begin
            gen_d    = '0;
            estado_d = ESPERA;
          end else begin
            gen_d = gen_q + 4'd1;
          end
        end
        ESPERA: begin
          tempo_d = tempo_dec;
          if (subida) begin
            db_lin_d = jogada_linha;
            db_col_d = jogada_coluna;
            estado_d = AVALIA;
          end else if (tempo_q == 15'd0) begin
            estado_d = FIM_TEMPO;
          end
        end
        AVALIA: begin
          if (hit) begin
            acertou_d = 1'b1;
            idx_d     = idx_q + 4'd1;
            streak_d  = (streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1;
            pontos_d  = (soma > PTS_MAX) ? PTS_MAX[PTS_W-1:0] : soma[PTS_W-1:0];
            tempo_d   = tempo_dec;
            // Finishing the sequence wins even if the timer has just hit zero.
            estado_d  = ultimo ? CONCLUIDO : ESPERA;
          end else begin
            errou_d  = 1'b1;
            streak_d = '0;
            tempo_d  = (tempo_dec > T_PEN_V) ? tempo_dec - T_PEN_V : 15'd0;
            // A penalty that empties the timer is caught back in ESPERA.
            estado_d = ESPERA;
          end
        end
        default: ;
      endcase
    end

    if (zera_pontos) begin
      pontos_d = '0;
      streak_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      lfsr_q       <= SEED;
      jogou_prev_q <= 1'b0;
      gen_q        <= '0;
      idx_q        <= '0;
      streak_q     <= '0;
      tempo_q      <= '0;
      pontos_q     <= '0;
      db_lin_q     <= '0;
      db_col_q     <= '0;
      acertou_q    <= 1'b0;
      errou_q      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        alvo_lin_q[i] <= '0;
        alvo_col_q[i] <= '0;
      end
    end else begin
      estado_q     <= estado_d;
      lfsr_q       <= lfsr_d;
      jogou_prev_q <= jogou;
      gen_q        <= gen_d;
      idx_q        <= idx_d;
      streak_q     <= streak_d;
      tempo_q      <= tempo_d;
      pontos_q     <= pontos_d;
      db_lin_q     <= db_lin_d;
      db_col_q     <= db_col_d;
      acertou_q    <= acertou_d;
      errou_q      <= errou_d;
      if (alvo_we) begin
        alvo_lin_q[gen_q] <= lfsr_q[W-1:0];
        alvo_col_q[gen_q] <= lfsr_q[2*W-1:W];
      end
    end
  end

  // The target is only meaningful while a move can be made or judged.
  assign linha_esperada  = ((estado_q == ESPERA) || (estado_q == AVALIA)) ? alvo_lin_q[idx_q] : '0;
  assign coluna_esperada = ((estado_q == ESPERA) || (estado_q == AVALIA)) ? alvo_col_q[idx_q] : '0;
  assign indice          = idx_q;
  assign pontos          = pontos_q;
  assign tempo           = tempo_q;
  assign acertou         = acertou_q;
  assign errou           = errou_q;
  assign completo        = (estado_q == CONCLUIDO);
  assign fim_tempo       = (estado_q == FIM_TEMPO);
  assign ocupado         = (estado_q == GERANDO) || (estado_q == ESPERA) || (estado_q == AVALIA);
  assign db_linha        = db_lin_q;
  assign db_coluna       = db_col_q;
  assign db_estado       = estado_q;

endmodule
